// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch defaults, fetch FSM states
// and the IF/ID register layout.
package cpu_pkg;
   localparam int          XLEN         = 32;
   localparam logic [31:0] PC_INC_DEF   = 32'd4;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HOLD
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] instr;
   } if_id_t;
endpackage

// File: rtl/fetch_stage_adder.sv
// 32-bit modular adder shared by the fetch stage; carry out is dropped.
module adder
   import cpu_pkg::*;
(
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic [XLEN-1:0] res
);
   assign res = op1 + op2;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem read issue, IF/ID register with
// a one-entry skid so a response never gets lost under decode backpressure.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic [31:0] if_instr
);
   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  next_pc;
   logic         inflight;
   logic [31:0]  tag;
   logic [31:0]  tag_plus4;
   if_id_t       if_id;
   if_id_t       skid;
   if_id_t       resp;
   logic         slot_free;

   adder u_adder (
      .op1 (pc),
      .op2 (PC_INC),
      .res (next_pc)
   );

   assign slot_free = !if_valid | if_ready;
   assign imem_addr = pc;
   assign imem_req  = (state == S_RUN) & slot_free & !redirect_valid;

   // The tag's successor is exactly the adder result at issue time, so it is
   // captured alongside the tag instead of needing a second adder.
   assign resp = '{pc: tag, pc_plus4: tag_plus4, instr: imem_rdata};

   assign if_pc       = if_id.pc;
   assign if_pc_plus4 = if_id.pc_plus4;
   assign if_instr    = if_id.instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_BOOT;
         pc        <= RESET_PC;
         inflight  <= 1'b0;
         tag       <= '0;
         tag_plus4 <= '0;
         if_valid  <= 1'b0;
         if_id     <= '0;
         skid      <= '0;
      end else if (redirect_valid) begin
         // In S_BOOT the pipeline is already empty, so the flush is a no-op.
         pc       <= {redirect_pc[31:2], 2'b00};
         if_valid <= 1'b0;
         skid     <= '0;
         inflight <= 1'b0;
         state    <= S_RUN;
      end else begin
         case (state)
            S_BOOT: state <= S_RUN;
            S_RUN: begin
               if (imem_req) begin
                  pc        <= next_pc;
                  tag       <= pc;
                  tag_plus4 <= next_pc;
               end
               inflight <= imem_req;
               if (inflight) begin
                  if (slot_free) begin
                     if_id    <= resp;
                     if_valid <= 1'b1;
                  end else begin
                     skid  <= resp;
                     state <= S_HOLD;
                  end
               end else if (if_ready) begin
                  if_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (if_ready) begin
                  if_id <= skid;
                  skid  <= '0;
                  state <= S_RUN;
               end
            end
            default: state <= S_BOOT;
         endcase
      end
   end
endmodule
